// File: rtl/seq_detector.sv
// Serial pattern detector: N-bit history shift register with fill-tracking FSM,
// one-cycle registered match pulse and a saturating hit counter.
module seq_detector #(
  parameter int              N        = 4,
  parameter logic [N-1:0]    PAT_INIT = 4'b1011,
  parameter int              CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             overlap,
  output logic             out,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int            FW   = $clog2(N + 1);
  localparam logic [FW-1:0] FULL = FW'(N);

  typedef enum logic [1:0] {EMPTY, FILLING, ARMED} state_e;

  state_e           state_q, state_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [N-1:0]     hist_q, hist_d;
  logic [N-1:0]     pat_q, pat_d;
  logic             out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [N-1:0]     hist_sh;
  logic [FW-1:0]    fill_inc;
  logic             match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign hist_sh = {hist_q[N-2:0], in};

  // Fill after one more accepted bit, clamped at N once armed.
  always_comb begin
    fill_inc = fill_q;
    case (state_q)
      EMPTY:   fill_inc = FW'(1);
      FILLING: fill_inc = fill_q + 1'b1;
      ARMED:   fill_inc = FULL;
      default: fill_inc = fill_q;
    endcase
  end

  assign match = (fill_inc == FULL) && (hist_sh == pat_q);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    out_d   = 1'b0;
    cnt_d   = cnt_q;
    if (pat_load) begin
      // A load wins over a coincident data bit; that bit is dropped.
      pat_d   = pat_in;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (in_valid) begin
      hist_d = hist_sh;
      out_d  = match;
      if (match) begin
        cnt_d = sat_inc(cnt_q);
      end
      if (match && !overlap) begin
        fill_d  = '0;
        state_d = EMPTY;
      end else begin
        fill_d  = fill_inc;
        state_d = (fill_inc == FULL) ? ARMED : FILLING;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= PAT_INIT;
      out_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out     = out_q;
  assign hit_cnt = cnt_q;

endmodule

// File: doc/seq_detector.md
SEQ_DETECTOR -- requirements
Module: seq_detector

Interface
REQ-001 Parameter N, default 4: pattern length in bits, legal range 2..16.
REQ-002 Parameter PAT_INIT, default 4'b1011 (N bits): pattern value loaded at reset.
REQ-003 Parameter CNT_W, default 8: hit counter width, legal range 1..16.
REQ-004 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  in is sampled this cycle when high.
REQ-008 in  input  1  serial data bit.
REQ-009 pat_load  input  1  load pat_in as the new pattern.
REQ-010 pat_in  input  N  new pattern; MSB is compared against the oldest bit.
REQ-011 overlap  input  1  1 = overlapping matches allowed, 0 = non-overlapping.
REQ-012 out  output  1  registered one-cycle match pulse.
REQ-013 hit_cnt  output  CNT_W  saturating count of matches.

Function
REQ-014 The block SHALL keep an N-bit history and a fill count; on each accepted bit: hist <= {hist[N-2:0], in}; fill <= min(fill+1, N).
REQ-015 The block SHALL implement a state machine with states EMPTY (fill=0), FILLING (0<fill<N) and ARMED (fill=N).
REQ-016 Transitions SHALL be: EMPTY->FILLING on an accepted bit; FILLING->ARMED when the accepted bit makes fill reach N; ARMED stays ARMED on an accepted bit unless the non-overlap rule applies.
REQ-017 A match SHALL occur on an accepted bit when the updated history equals the pattern and the updated fill equals N.
REQ-018 out SHALL be high for exactly the one cycle following the clock edge at which the matching bit was sampled (latency 1), and low otherwise.
REQ-019 With overlap=1, after a match the history and fill SHALL be retained, so the next match can occur after as few as 1 further bit.
REQ-020 With overlap=0, a match SHALL clear fill to 0 (state EMPTY), so the next match needs N further accepted bits.
REQ-021 overlap SHALL be sampled on the same edge as the bit it applies to; changing it mid-stream SHALL NOT alter the history.
REQ-022 When in_valid=0 and pat_load=0, history, fill and state SHALL hold and out SHALL be 0 on the next cycle.
REQ-023 pat_load=1 SHALL update the pattern to pat_in, clear fill to 0 (EMPTY) and force out=0 on the next cycle.
REQ-024 When pat_load and in_valid are high in the same cycle, pat_load SHALL take priority and the in bit SHALL be discarded.
REQ-025 hit_cnt SHALL increment by 1 on each match and saturate at 2^CNT_W-1, never wrapping.
REQ-026 hit_cnt SHALL be cleared only by reset; pat_load SHALL NOT clear it.

Reset
REQ-027 On rst_n=0 the block SHALL, immediately and independent of clk, set out=0, hit_cnt=0, history=0, fill=0 (EMPTY) and pattern=PAT_INIT.
REQ-028 A reset asserted mid-stream SHALL discard any partial match; after release, N new accepted bits SHALL be required before any match.
REQ-029 The first accepted bit SHALL be the one sampled on the first rising edge after rst_n deasserts.

Verification
REQ-030 Reset check: drive rst_n=0 asynchronously mid-cycle -> out=0 and hit_cnt=0 at once, and pattern=4'b1011.
REQ-031 Overlap check: N=4, pattern 1011, overlap=1, bits 1,0,1,1,0,1,1 on consecutive cycles -> out pulses after bit 4 and after bit 7; hit_cnt=2.
REQ-032 Non-overlap check: same stream with overlap=0 -> out pulses only after bit 4; hit_cnt=1.
REQ-033 Gap check: bits 1,0 then in_valid=0 for 3 cycles, then bits 1,1 -> a single out pulse one cycle after the final 1, and no pulse during the gap.
REQ-034 Load collision check: after bits 1,0,1, assert pat_load=1 with pat_in=0110 and in_valid=1, in=1 in the same cycle, then send 0,1,1,0 -> no pulse from the old pattern; out pulses after the final 0; hit_cnt increments by 1.
REQ-035 Saturation and mid-stream reset check: CNT_W=2, 5 overlapping matches -> hit_cnt stops at 3; then reset after bits 1,0,1 and send 1 -> no pulse.
